// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: routes ioctl download bytes into per-channel word writes.
// Define LOADER_CHECKSUM_EN for a 16-bit running sum of accepted bytes.
module ioctl_rom_loader #(
    parameter int NUM_CH     = 2,
    parameter int INDEX_BASE = 0,
    parameter int MEM_AW     = 12,
    parameter int WORD_BYTES = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk_48,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic                    ioctl_wr,
    input  logic [24:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    input  logic [7:0]              ioctl_index,
    output logic                    ioctl_wait,
    output logic [NUM_CH-1:0]       mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_data,
    input  logic                    mem_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             checksum
);
    localparam int DW = 8 * WORD_BYTES;
    localparam int SH = $clog2(WORD_BYTES);
    localparam int LW = (SH > 0) ? SH : 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] LAST = LW'(WORD_BYTES - 1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] CNT_HI = (PW+1)'(FIFO_DEPTH - 1);
    localparam logic [PW:0] ONE_C = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam logic [7:0] IB = 8'(INDEX_BASE);
    localparam logic [8:0] NC = 9'(NUM_CH);

    typedef enum logic [2:0] {
        C_IDLE, C_LOAD, C_FLUSH, C_DRAIN, C_DONE
    } ctrl_t;
    typedef enum logic {W_IDLE, W_WRITE} wst_t;

    ctrl_t ctrl;
    wst_t  wst;
    logic  dl_q;

    logic [7:0]        idx_off;
    logic [24:0]       wa_full;
    logic [LW-1:0]     lane;
    logic [CW-1:0]     b_ch;
    logic [MEM_AW-1:0] b_addr;
    logic [DW-1:0]     b_word, b_mask, merged;
    logic ch_ok, addr_ok, load_ok, acc, rise;

    logic              p_valid, p_full;
    logic [CW-1:0]     p_ch;
    logic [MEM_AW-1:0] p_addr;
    logic [DW-1:0]     p_data;
    logic              same, eject;

    logic              push_v;
    logic [CW-1:0]     push_ch;
    logic [MEM_AW-1:0] push_addr;
    logic [DW-1:0]     push_data;

    logic [CW-1:0]     f_ch   [FIFO_DEPTH];
    logic [MEM_AW-1:0] f_addr [FIFO_DEPTH];
    logic [DW-1:0]     f_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, rd1;
    logic [PW:0]       count;
    logic              full, pop, space, drain_ok;

    assign idx_off = ioctl_index - IB;
    assign wa_full = ioctl_addr >> SH;
    assign lane    = (WORD_BYTES == 1) ? '0 : ioctl_addr[LW-1:0];
    assign ch_ok   = (ioctl_index >= IB) && ({1'b0, idx_off} < NC);
    assign addr_ok = (wa_full >> MEM_AW) == 25'd0;
    assign b_ch    = idx_off[CW-1:0];
    assign b_addr  = wa_full[MEM_AW-1:0];
    assign b_word  = DW'(ioctl_dout) << {lane, 3'b000};
    assign b_mask  = DW'(8'hFF) << {lane, 3'b000};

    assign full    = count == CNT_FULL;
    assign pop     = (wst == W_WRITE) && mem_ready;
    assign space   = !full || pop;
    assign load_ok = (ctrl == C_IDLE) || (ctrl == C_LOAD);
    assign acc     = ioctl_download && ioctl_wr && load_ok
                     && ch_ok && addr_ok && !full;
    assign rise    = ioctl_download && !dl_q;

    // A completed-but-unpushed partial (p_full) arises only when two words
    // need the FIFO in the same cycle; it is pushed on the next cycle.
    assign same   = p_valid && !p_full && p_ch == b_ch && p_addr == b_addr;
    assign eject  = p_valid && space
                    && (p_full || (acc && !same) || ctrl == C_FLUSH);
    assign merged = ((same ? p_data : '0) & ~b_mask) | b_word;

    always_comb begin
        push_v    = 1'b0;
        push_ch   = p_ch;
        push_addr = p_addr;
        push_data = p_data;
        if (eject) begin
            push_v = 1'b1;
        end else if (acc && lane == LAST) begin
            push_v    = 1'b1;
            push_ch   = b_ch;
            push_addr = b_addr;
            push_data = merged;
        end
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            p_valid <= 1'b0;
            p_full  <= 1'b0;
            p_ch    <= '0;
            p_addr  <= '0;
            p_data  <= '0;
        end else if (eject) begin
            p_valid <= acc;
            p_full  <= acc && lane == LAST;
            p_ch    <= b_ch;
            p_addr  <= b_addr;
            p_data  <= b_word;
        end else if (acc) begin
            p_valid <= lane != LAST;
            p_full  <= 1'b0;
            p_ch    <= b_ch;
            p_addr  <= b_addr;
            p_data  <= merged;
        end
    end

    always_ff @(posedge clk_48) begin
        if (push_v) begin
            f_ch[wr_ptr]   <= push_ch;
            f_addr[wr_ptr] <= push_addr;
            f_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_v) wr_ptr <= wr_ptr + ONE_P;
            if (pop) rd_ptr <= rd_ptr + ONE_P;
            if (push_v && !pop) count <= count + ONE_C;
            else if (!push_v && pop) count <= count - ONE_C;
        end
    end

    assign rd1 = rd_ptr + ONE_P;

    // Back-to-back writes take the next entry, or the word being pushed now.
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            wst      <= W_IDLE;
            mem_we   <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            unique case (wst)
                W_IDLE: if (count != '0) begin
                    wst      <= W_WRITE;
                    mem_we   <= NUM_CH'(1) << f_ch[rd_ptr];
                    mem_addr <= f_addr[rd_ptr];
                    mem_data <= f_data[rd_ptr];
                end
                W_WRITE: if (mem_ready) begin
                    if (count > ONE_C) begin
                        mem_we   <= NUM_CH'(1) << f_ch[rd1];
                        mem_addr <= f_addr[rd1];
                        mem_data <= f_data[rd1];
                    end else if (push_v) begin
                        mem_we   <= NUM_CH'(1) << push_ch;
                        mem_addr <= push_addr;
                        mem_data <= push_data;
                    end else begin
                        wst    <= W_IDLE;
                        mem_we <= '0;
                    end
                end
                default: wst <= W_IDLE;
            endcase
        end
    end

    assign drain_ok = !p_valid && !push_v
                      && ((count == '0 && wst == W_IDLE)
                          || (pop && count == ONE_C));

    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) begin
            ctrl       <= C_IDLE;
            dl_q       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ioctl_wait <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            done <= 1'b0;
            if (ioctl_download && ioctl_wr && !acc) err <= 1'b1;
            else if (rise) err <= 1'b0;
            ioctl_wait <= (count >= CNT_HI)
                          || (ioctl_download && ctrl != C_IDLE
                              && ctrl != C_LOAD);
            unique case (ctrl)
                C_IDLE:  if (ioctl_download) ctrl <= C_LOAD;
                C_LOAD:  if (!ioctl_download) ctrl <= C_FLUSH;
                C_FLUSH: begin
                    if (drain_ok) begin
                        ctrl <= C_DONE;
                        done <= 1'b1;
                    end else if (!p_valid || eject) begin
                        ctrl <= C_DRAIN;
                    end
                end
                C_DRAIN: if (drain_ok) begin
                    ctrl <= C_DONE;
                    done <= 1'b1;
                end
                C_DONE:  ctrl <= C_IDLE;
                default: ctrl <= C_IDLE;
            endcase
        end
    end

    assign busy = (ctrl != C_IDLE) || (count != '0);

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum;
    always_ff @(posedge clk_48 or posedge reset) begin
        if (reset) sum <= 16'h0000;
        else if (rise) sum <= acc ? {8'h00, ioctl_dout} : 16'h0000;
        else if (acc) sum <= sum + {8'h00, ioctl_dout};
    end
    assign checksum = sum;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: doc/ioctl_rom_loader.md
# ioctl_rom_loader

Parametrised download router between the MiSTer/Verilator ioctl byte stream and on-chip memories. It routes bytes by `ioctl_index` to one of `NUM_CH` memory channels and packs them into `WORD_BYTES`-wide little-endian words. Completed words are buffered in a small FIFO and written out through a ready/valid-style memory port. When the buffer is nearly full it drives real `ioctl_wait` backpressure. It sits between the sim/MiSTer top and the cartridge/BIOS RAMs of the core.

## Interface
- `NUM_CH`, 2: number of target memories; channel = `ioctl_index - INDEX_BASE`
- `INDEX_BASE`, 0: first `ioctl_index` value routed
- `MEM_AW`, 12: word address width per channel
- `WORD_BYTES`, 1: bytes per memory word; legal values 1, 2, 4
- `FIFO_DEPTH`, 4: word buffer depth; power of 2, ≥2

Ports:
- `clk_48`  in  1  sole clock
- `reset`  in  1  asynchronous, active-high
- `ioctl_download`  in  1  download window
- `ioctl_wr`  in  1  one-cycle byte strobe
- `ioctl_addr`  in  25  byte address
- `ioctl_dout`  in  8  byte data
- `ioctl_index`  in  8  target selector
- `ioctl_wait`  out  1  backpressure to host
- `mem_we`  out  NUM_CH  one-hot write request
- `mem_addr`  out  MEM_AW  word address
- `mem_data`  out  8*WORD_BYTES  word data
- `mem_ready`  in  1  memory accepts the current write
- `busy`  out  1  download active or FIFO non-empty
- `done`  out  1  one-cycle pulse when the load is fully written
- `err`  out  1  sticky drop flag
- `checksum`  out  16  running byte sum (see Configuration)

## Operation
- **Accept:** a byte is accepted when `ioctl_download & ioctl_wr` and the channel is < `NUM_CH`, word address (`ioctl_addr >> log2(WORD_BYTES)`) is < 2^MEM_AW, and the FIFO is not full.
  - A byte failing any condition is dropped and sets `err`.
  - `err` clears on the rising edge of `ioctl_download`.
- **Pack:** the byte lane is `ioctl_addr[log2(WORD_BYTES)-1:0]`. Lane 0 occupies the LSBs.
  - A partial word register holds channel, word address, data, and a valid flag.
  - The word is pushed when lane `WORD_BYTES-1` is written.
  - The partial word is also pushed early, with unwritten lanes zero, when:
    - an accepted byte targets a different channel or word address (the new byte then starts a fresh partial word in the same cycle), or
    - `ioctl_download` falls.
- **FIFO:** entries are {channel, address, data}. Push and pop in the same cycle are legal; the count is unchanged.
- **Writer FSM:**
  - IDLE: wait for FIFO non-empty.
  - WRITE: hold `mem_we[ch]`/`mem_addr`/`mem_data` stable until `mem_ready`=1 is sampled, then pop. Go back-to-back to WRITE if more entries remain, else IDLE.
- **Control FSM:**
  - IDLE →LOAD on `ioctl_download` rising.
  - LOAD →FLUSH on falling edge.
  - FLUSH pushes any partial word (one cycle) →DRAIN.
  - DRAIN →DONE when the FIFO is empty and the writer is IDLE.
  - DONE pulses `done` for one cycle →IDLE.
  - A new rising edge in DRAIN is held off: `ioctl_wait` stays 1 until DONE.
- **Backpressure:** `ioctl_wait` is registered and is 1 when the FIFO count ≥ `FIFO_DEPTH-1`, or the FSM is in FLUSH/DRAIN/DONE while `ioctl_download`=1.
- **Outputs:** `busy` = state≠IDLE or FIFO non-empty.

## Timing
- Reset values: `ioctl_wait`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `err`=0, `checksum`=0. Reset clears the FIFO, the partial word, and both FSMs, including mid-download; no write is issued after reset.
- Latency: final-lane `ioctl_wr` at cycle N → FIFO push at N+1 → `mem_we` high at N+2 if the FIFO was empty.
- With `mem_ready` tied 1, sustained throughput is one word per cycle.
- `ioctl_wait` reflects the FIFO count with one cycle of latency. Headroom of one entry absorbs the in-flight byte.
- `done` asserts the cycle after the last `mem_ready` handshake, or 2 cycles after the falling edge if nothing is pending.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` = 16-bit wrap-around sum of every accepted byte.
  - Cleared on the `ioctl_download` rising edge; held after DONE.
- Not defined: `checksum` is constant 0 and no adder is synthesised.

## Test plan
- **Single-byte path:** `WORD_BYTES`=1, index 0, bytes 0x11,0x22 at addr 0,1, `mem_ready`=1 → `mem_we`=01 at addr 0 data 0x11, then addr 1 data 0x22; `done` pulse; `err`=0.
- **Packing and partial flush:** `WORD_BYTES`=2, index 1, bytes 0xAA,0xBB,0xCC at addr 0..2 → `mem_we`=10 with writes {0, 0xBBAA}, then {1, 0x00CC} flushed at download end.
- **Backpressure:** `FIFO_DEPTH`=4, `mem_ready`=0 held, 4 words streamed → `ioctl_wait`=1 after 3rd push. Release `mem_ready` → 4 writes in order; `ioctl_wait` drops.
- **Errors:** index 5 with `NUM_CH`=2, or addr 0x1000 with `MEM_AW`=12 → no `mem_we`, `err`=1; next download start clears `err`.
- **Reset mid-load:** `reset` pulsed with 2 entries queued and `mem_ready`=0 → all outputs 0 next cycle; no write afterward.
- **Checksum:** with `LOADER_CHECKSUM_EN`, bytes 0xFF,0xFF,0x03 → `checksum`=0x0201.
